// File: rtl/clkdiv.sv
// Free-running clock divider: one up-counter, three outputs taken straight from counter bits.
// Latency: each output is a flop bit, so it changes on the same edge the counter does.
// No handshake and no backpressure: the counter advances on every clock edge while clr is high.
module clkdiv #(
    parameter int CNT_WIDTH = 24,
    parameter int TAP_25    = 0,
    parameter int TAP_190   = 17,
    parameter int TAP_3     = 23
) (
    input  logic clk,
    input  logic clr,
    output logic clk190,
    output logic clk25,
    output logic clk3
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] q;

    // A tap that falls outside the counter is a build error, not a silent zero.
    generate
        if (TAP_25 < 0 || TAP_25 >= CNT_WIDTH ||
            TAP_190 < 0 || TAP_190 >= CNT_WIDTH ||
            TAP_3 < 0 || TAP_3 >= CNT_WIDTH) begin : g_bad_tap
            $error("clkdiv: tap index outside counter width");
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else begin
            q <= q + CNT_ONE;
        end
    end

    assign clk25  = q[TAP_25];
    assign clk190 = q[TAP_190];
    assign clk3   = q[TAP_3];

endmodule

// File: tb/tb_clkdiv.sv
// Randomized bench for clkdiv: three instances (default, 12-bit, 8-bit) against an edge-count model.
module tb_clkdiv;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic a190, a25, a3;
    logic b190, b25, b3;
    logic c190, c25, c3;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int last_rise = -1;
    logic prev_c3 = 1'b0;

    clkdiv dut_def (
        .clk    (clk),
        .clr    (clr),
        .clk190 (a190),
        .clk25  (a25),
        .clk3   (a3)
    );

    clkdiv #(.CNT_WIDTH(12), .TAP_25(0), .TAP_190(5), .TAP_3(11)) dut12 (
        .clk    (clk),
        .clr    (clr),
        .clk190 (b190),
        .clk25  (b25),
        .clk3   (b3)
    );

    clkdiv #(.CNT_WIDTH(8), .TAP_25(0), .TAP_190(3), .TAP_3(7)) dut8 (
        .clk    (clk),
        .clr    (clr),
        .clk190 (c190),
        .clk25  (c25),
        .clk3   (c3)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edges since release %0d)", tag, got, exp, n);
        end
    endtask

    // Reference: output k is bit k of (edges since release) modulo 2^width.
    function automatic logic mbit(input int cnt, input int w, input int k);
        logic [63:0] m;
        m = 64'(longint'(cnt) % (longint'(1) << w));
        return m[k];
    endfunction

    task automatic check_all();
        chk("def_clk25",  {31'd0, a25},  {31'd0, mbit(n, 24, 0)});
        chk("def_clk190", {31'd0, a190}, {31'd0, mbit(n, 24, 17)});
        chk("def_clk3",   {31'd0, a3},   {31'd0, mbit(n, 24, 23)});
        chk("w12_clk25",  {31'd0, b25},  {31'd0, mbit(n, 12, 0)});
        chk("w12_clk190", {31'd0, b190}, {31'd0, mbit(n, 12, 5)});
        chk("w12_clk3",   {31'd0, b3},   {31'd0, mbit(n, 12, 11)});
        chk("w8_clk25",   {31'd0, c25},  {31'd0, mbit(n, 8, 0)});
        chk("w8_clk190",  {31'd0, c190}, {31'd0, mbit(n, 8, 3)});
        chk("w8_clk3",    {31'd0, c3},   {31'd0, mbit(n, 8, 7)});
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {23'd0, a25, a190, a3, b25, b190, b3, c25, c190, c3}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (clr) n++;
        #1;
        check_all();
        if (c3 && !prev_c3) begin
            if (last_rise >= 0) chk("w8_clk3_period", n - last_rise, 256);
            last_rise = n;
        end
        prev_c3 = c3;
    endtask

    // Assert clr between edges, confirm the drop is immediate, hold, then release mid-low phase.
    task automatic do_reset(input int off, input int hold);
        @(negedge clk);
        #(off);
        clr = 1'b0;
        #1;
        check_zero("rst_async_drop");
        n = 0;
        last_rise = -1;
        prev_c3 = 1'b0;
        repeat (hold) step();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_zero("rst_release_idle");
    endtask

    initial begin
        #2;
        clr = 1'b0;
        #1;
        check_zero("rst_before_edge");
        repeat (3) step();
        check_zero("rst_held");

        @(negedge clk);
        clr = 1'b1;
        step();
        chk("clk25_edge1", {31'd0, b25}, 32'd1);
        step();
        chk("clk25_edge2", {31'd0, b25}, 32'd0);

        for (int i = 0; i < 4400; i++) begin
            step();
            if (n == 31)   chk("w12_clk190_pre_rise", {31'd0, b190}, 32'd0);
            if (n == 32)   chk("w12_clk190_rise",     {31'd0, b190}, 32'd1);
            if (n == 64)   chk("w12_clk190_fall",     {31'd0, b190}, 32'd0);
            if (n == 2048) chk("w12_clk3_rise",       {31'd0, b3},   32'd1);
            if (n == 4096) chk("w12_wrap_zero",       {29'd0, b25, b190, b3}, 32'd0);
        end

        for (int r = 0; r < 6; r++) begin
            int run;
            run = int'($urandom_range(40, 3000));
            repeat (run) step();
            do_reset(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
            step();
            chk("restart_edge1", {31'd0, b25}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
